// File: rtl/jk_drive_sequencer_if.sv
// Request/response and JK-bank drive signals of jk_drive_sequencer.
// The slave modport is the sequencer; the master modport is the requester plus bank.
interface jk_drive_sequencer_if #(
  parameter int WIDTH = 4
);
  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] req_target;
  logic [1:0]       req_mode;
  logic [WIDTH-1:0] q_in;
  logic [WIDTH-1:0] j_out;
  logic [WIDTH-1:0] k_out;
  logic             busy;
  logic             resp_valid;
  logic             resp_ok;
  logic [3:0]       resp_retries;

  modport slave (
    input  req_valid, req_target, req_mode, q_in,
    output req_ready, j_out, k_out, busy, resp_valid, resp_ok, resp_retries
  );

  modport master (
    output req_valid, req_target, req_mode, q_in,
    input  req_ready, j_out, k_out, busy, resp_valid, resp_ok, resp_retries
  );
endinterface

// File: rtl/jk_drive_sequencer.sv
// Drives a bank of JK flip-flops toward a requested state for one edge at a time,
// verifies the result and retries up to MAX_RETRY times before reporting.
module jk_drive_sequencer #(
  parameter int WIDTH     = 4,
  parameter int MAX_RETRY = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  jk_drive_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, DRIVE, CHECK} state_t;

  localparam logic [3:0] RETRY_LIMIT = 4'(MAX_RETRY);

  state_t           state_q, state_n;
  logic [WIDTH-1:0] target_q, target_n;
  logic [1:0]       mode_q, mode_n;
  logic [3:0]       retry_q, retry_n;
  logic [WIDTH-1:0] j_q, j_n;
  logic [WIDTH-1:0] k_q, k_n;
  logic             ready_q, ready_n;
  logic             busy_q, busy_n;
  logic             rv_q, rv_n;
  logic             ok_q, ok_n;
  logic [3:0]       rtr_q, rtr_n;

  // Returns {j, k}; mode 2'b11 falls back to minimal excitation.
  function automatic logic [2*WIDTH-1:0] excite(input logic [WIDTH-1:0] q,
                                                input logic [WIDTH-1:0] t,
                                                input logic [1:0]       mode);
    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;
    case (mode)
      2'b01: begin
        j = q ^ t;
        k = q ^ t;
      end
      2'b10: begin
        j = t;
        k = ~t;
      end
      default: begin
        j = ~q & t;
        k = q & ~t;
      end
    endcase
    return {j, k};
  endfunction

  always_comb begin
    state_n  = state_q;
    target_n = target_q;
    mode_n   = mode_q;
    retry_n  = retry_q;
    j_n      = '0;
    k_n      = '0;
    rv_n     = 1'b0;
    ok_n     = ok_q;
    rtr_n    = rtr_q;

    case (state_q)
      IDLE: begin
        if (bus.req_valid && ready_q) begin
          target_n   = bus.req_target;
          mode_n     = bus.req_mode;
          retry_n    = '0;
          {j_n, k_n} = excite(bus.q_in, bus.req_target, bus.req_mode);
          state_n    = DRIVE;
        end
      end
      DRIVE: state_n = CHECK;
      CHECK: begin
        if (bus.q_in == target_q) begin
          state_n = IDLE;
          rv_n    = 1'b1;
          ok_n    = 1'b1;
          rtr_n   = retry_q;
        end else if (retry_q < RETRY_LIMIT) begin
          retry_n    = retry_q + 4'd1;
          {j_n, k_n} = excite(bus.q_in, target_q, mode_q);
          state_n    = DRIVE;
        end else begin
          state_n = IDLE;
          rv_n    = 1'b1;
          ok_n    = 1'b0;
          rtr_n   = RETRY_LIMIT;
        end
      end
      default: state_n = IDLE;
    endcase

    // Handshake flags are registered copies of where the FSM is heading.
    ready_n = (state_n == IDLE);
    busy_n  = (state_n != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      retry_q <= '0;
      j_q     <= '0;
      k_q     <= '0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      rv_q    <= 1'b0;
      ok_q    <= 1'b0;
      rtr_q   <= '0;
    end else begin
      state_q <= state_n;
      retry_q <= retry_n;
      j_q     <= j_n;
      k_q     <= k_n;
      ready_q <= ready_n;
      busy_q  <= busy_n;
      rv_q    <= rv_n;
      ok_q    <= ok_n;
      rtr_q   <= rtr_n;
    end
  end

  // The latched request is only meaningful while busy, so it carries no reset.
  always_ff @(posedge clk) begin
    target_q <= target_n;
    mode_q   <= mode_n;
  end

  assign bus.req_ready    = ready_q;
  assign bus.busy         = busy_q;
  assign bus.j_out        = j_q;
  assign bus.k_out        = k_q;
  assign bus.resp_valid   = rv_q;
  assign bus.resp_ok      = ok_q;
  assign bus.resp_retries = rtr_q;

endmodule

// File: tb/tb_jk_drive_sequencer.sv
// Bench for jk_drive_sequencer: a JK bank with optional stuck-at-0 bits and a
// per-request reference model of drive/retry/response behaviour.
module tb_jk_drive_sequencer;
  localparam int W    = 4;
  localparam int MAXR = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  jk_drive_sequencer_if #(.WIDTH(W)) bus ();

  jk_drive_sequencer #(.WIDTH(W), .MAX_RETRY(MAXR)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // JK flip-flop bank, characteristic equation Q+ = J~Q | ~K Q, with stuck-at-0 mask
  logic [W-1:0] bank_q;
  logic [W-1:0] bank_init = '0;
  logic         bank_load = 1'b1;
  logic [W-1:0] stuck0    = '0;

  always @(posedge clk) begin
    if (bank_load) bank_q <= bank_init;
    else           bank_q <= ((bus.j_out & ~bank_q) | (~bus.k_out & bank_q)) & ~stuck0;
  end
  assign bus.q_in = bank_q;

  int total  = 0;
  int passes = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Reference excitation written straight from the per-bit rule table
  task automatic ref_excite(input logic [W-1:0] q, input logic [W-1:0] t, input logic [1:0] m,
                            output logic [W-1:0] j, output logic [W-1:0] k);
    for (int b = 0; b < W; b++) begin
      if (m == 2'b10) begin
        j[b] = t[b];
        k[b] = !t[b];
      end else if (q[b] == t[b]) begin
        j[b] = 1'b0;
        k[b] = 1'b0;
      end else if (m == 2'b01) begin
        j[b] = 1'b1;
        k[b] = 1'b1;
      end else begin
        j[b] = t[b];
        k[b] = q[b];
      end
    end
  endtask

  function automatic logic [W-1:0] ref_bank(input logic [W-1:0] q, input logic [W-1:0] j,
                                            input logic [W-1:0] k);
    logic [W-1:0] r;
    for (int b = 0; b < W; b++) begin
      case ({j[b], k[b]})
        2'b00:   r[b] = q[b];
        2'b10:   r[b] = 1'b1;
        2'b01:   r[b] = 1'b0;
        default: r[b] = !q[b];
      endcase
    end
    return r;
  endfunction

  task automatic load_bank(input logic [W-1:0] v);
    bank_init = v;
    bank_load = 1'b1;
    @(negedge clk);
    bank_load = 1'b0;
  endtask

  // One request, from the cycle it is presented through the response cycle.
  // With keep set, req_valid stays high with a second request while busy.
  task automatic do_op(input logic [W-1:0] t, input logic [1:0] m, input bit keep,
                       input logic [W-1:0] nt, input logic [1:0] nm);
    logic [W-1:0] ej [0:15];
    logic [W-1:0] ek [0:15];
    logic [W-1:0] cur;
    int n;
    bit okx;
    int wait_cnt;

    wait_cnt = 0;
    while (!bus.req_ready && wait_cnt < 50) begin
      @(negedge clk);
      wait_cnt++;
    end
    if (!bus.req_ready) begin
      check("ready_wait", {31'd0, bus.req_ready}, 32'd1);
      return;
    end

    cur = bank_q;
    n   = 0;
    okx = 1'b0;
    for (int a = 0; a <= MAXR; a++) begin
      ref_excite(cur, t, m, ej[a], ek[a]);
      cur = ref_bank(cur, ej[a], ek[a]) & ~stuck0;
      n   = a + 1;
      if (cur == t) begin
        okx = 1'b1;
        break;
      end
    end

    bus.req_valid  = 1'b1;
    bus.req_target = t;
    bus.req_mode   = m;
    @(negedge clk);
    if (keep) begin
      bus.req_target = nt;
      bus.req_mode   = nm;
    end else begin
      bus.req_valid = 1'b0;
    end

    for (int a = 0; a < n; a++) begin
      check("drive_j", 32'(bus.j_out), 32'(ej[a]));
      check("drive_k", 32'(bus.k_out), 32'(ek[a]));
      check("drive_busy", {31'd0, bus.busy}, 32'd1);
      check("drive_ready", {31'd0, bus.req_ready}, 32'd0);
      @(negedge clk);
      check("check_jk", 32'({bus.j_out, bus.k_out}), 32'd0);
      check("check_rv", {31'd0, bus.resp_valid}, 32'd0);
      @(negedge clk);
    end
    check("resp_valid", {31'd0, bus.resp_valid}, 32'd1);
    check("resp_ok", {31'd0, bus.resp_ok}, {31'd0, okx});
    check("resp_retries", 32'(bus.resp_retries), 32'(n - 1));
    check("resp_ready", {31'd0, bus.req_ready}, 32'd1);
    check("resp_busy", {31'd0, bus.busy}, 32'd0);
    if (okx) check("bank_final", 32'(bank_q), 32'(t));
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      check("idle_rv", {31'd0, bus.resp_valid}, 32'd0);
      check("idle_jk", 32'({bus.j_out, bus.k_out}), 32'd0);
    end
  endtask

  initial begin
    logic [W-1:0] hold;
    bus.req_valid  = 1'b0;
    bus.req_target = '0;
    bus.req_mode   = 2'b00;

    // Reset with bank preset to 0000
    repeat (2) @(negedge clk);
    rst       = 1'b0;
    bank_load = 1'b0;
    check("rst_ready", {31'd0, bus.req_ready}, 32'd1);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_rv", {31'd0, bus.resp_valid}, 32'd0);
    check("rst_ok", {31'd0, bus.resp_ok}, 32'd0);
    check("rst_retries", 32'(bus.resp_retries), 32'd0);
    check("rst_j", 32'(bus.j_out), 32'd0);
    check("rst_k", 32'(bus.k_out), 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("rst_bank_hold", 32'(bank_q), 32'd0);
    end

    // Minimal, toggle and force modes, explicit excitation values included
    do_op(4'b1010, 2'b00, 1'b0, '0, 2'b00);
    idle(2);
    check("min_bank", 32'(bank_q), 32'b1010);
    do_op(4'b0110, 2'b01, 1'b0, '0, 2'b00);
    idle(1);
    do_op(4'b0011, 2'b10, 1'b0, '0, 2'b00);
    idle(1);

    // Bit 0 stuck at 0: three drives, then failure with two retries
    load_bank(4'b0000);
    stuck0 = 4'b0001;
    @(negedge clk);
    do_op(4'b0001, 2'b00, 1'b0, '0, 2'b00);
    check("stuck_ok", {31'd0, bus.resp_ok}, 32'd0);
    check("stuck_retries", 32'(bus.resp_retries), 32'd2);
    stuck0 = '0;
    idle(2);

    // Reset during CHECK aborts with no response
    bus.req_valid  = 1'b1;
    bus.req_target = 4'b1111;
    bus.req_mode   = 2'b00;
    @(negedge clk);
    bus.req_valid = 1'b0;
    check("abort_drive_busy", {31'd0, bus.busy}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", {31'd0, bus.busy}, 32'd0);
    check("abort_ready", {31'd0, bus.req_ready}, 32'd1);
    check("abort_rv", {31'd0, bus.resp_valid}, 32'd0);
    check("abort_jk", 32'({bus.j_out, bus.k_out}), 32'd0);
    idle(3);

    // Request held off while busy, accepted in the response cycle
    load_bank(4'b0000);
    do_op(4'b0101, 2'b00, 1'b1, 4'b1111, 2'b01);
    do_op(4'b1111, 2'b01, 1'b0, '0, 2'b00);

    // Back-to-back, then a target equal to the current state
    do_op(4'b1000, 2'b10, 1'b0, '0, 2'b00);
    do_op(4'b0111, 2'b00, 1'b0, '0, 2'b00);
    hold = bank_q;
    do_op(hold, 2'b01, 1'b0, '0, 2'b00);
    check("same_retries", 32'(bus.resp_retries), 32'd0);
    idle(1);

    // Randomized requests, modes, gaps and stuck masks
    for (int r = 0; r < 30; r++) begin
      stuck0 = ($urandom_range(0, 3) == 0) ? W'($urandom) : '0;
      @(negedge clk);
      do_op(W'($urandom), 2'($urandom_range(0, 3)), 1'b0, '0, 2'b00);
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 2));
    end
    stuck0 = '0;
    idle(2);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, observed running expected finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/jk_drive_sequencer.md
Name: jk_drive_sequencer

Overview:
- Upstream command stage for a bank of WIDTH JK flip-flops, each with j, k, clk and outputs q, qb.
- Accepts a target state word over a valid/ready handshake and computes per-bit J/K excitation from the bank's current q. It drives j/k for exactly one clock edge, then checks that the bank reached the target.
- On mismatch it re-drives, up to MAX_RETRY times, then reports pass/fail with a one-cycle response pulse.

Parameters:
- WIDTH, 4, number of JK flip-flops in the driven bank (1..32).
- MAX_RETRY, 2, extra drive attempts after a failed check (0..15).

Ports:
- clk  input  1  rising-edge clock, shared with the JK bank.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  sequencer can accept a request.
- req_target  input  WIDTH  desired next state of the bank.
- req_mode  input  2  excitation mode: 00 minimal, 01 toggle, 10 force, 11 treated as 00.
- q_in  input  WIDTH  current q of the JK bank.
- j_out  output  WIDTH  J inputs of the bank.
- k_out  output  WIDTH  K inputs of the bank.
- busy  output  1  high in DRIVE or CHECK.
- resp_valid  output  1  one-cycle completion pulse.
- resp_ok  output  1  the bank matched the target; valid with resp_valid.
- resp_retries  output  4  retries used; valid with resp_valid.

Behaviour:
- All outputs are registered.
- Reset (rst high at an edge):
  - state goes to IDLE;
  - j_out and k_out = 0 (hold), resp_valid = 0, resp_ok = 0, resp_retries = 0, busy = 0;
  - req_ready = 1 from the first cycle after reset.
- Reset wins over every other event, including mid-DRIVE or mid-CHECK. An aborted operation produces no response. The bank's state is then undefined from the sequencer's view, because the bank has no reset.
- States are IDLE, DRIVE and CHECK; req_ready = 1 only in IDLE.
- IDLE:
  - at an edge with req_valid and req_ready both high, latch req_target and req_mode;
  - clear the retry count;
  - load j_out/k_out from the excitation of (q_in, req_target) sampled at that edge;
  - go to DRIVE.
- DRIVE lasts exactly one cycle:
  - the bank samples j_out/k_out at the closing edge;
  - at that edge j_out and k_out return to 0 and the state goes to CHECK.
- CHECK lasts exactly one cycle and compares q_in with the latched target at its closing edge:
  - match: go to IDLE, resp_valid = 1, resp_ok = 1, resp_retries = retry count.
  - mismatch with retry count < MAX_RETRY: increment the count, reload j/k from (q_in, target), go to DRIVE.
  - mismatch with retry count == MAX_RETRY: go to IDLE, resp_valid = 1, resp_ok = 0, resp_retries = MAX_RETRY.
- Per-bit excitation, with q the current bit and t the target bit:
  - minimal: q=0, t=1 gives j=1, k=0; q=1, t=0 gives j=0, k=1; q==t gives j=0, k=0.
  - toggle: q!=t gives j=1, k=1; q==t gives j=0, k=0.
  - force: t=1 gives j=1, k=0; t=0 gives j=0, k=1, regardless of q.
- Latency:
  - accept at edge E0, bank updates at E1, resp_valid is high during the cycle after E2;
  - each retry adds 2 cycles.
- resp_valid is a single-cycle pulse with no backpressure. resp_ok and resp_retries hold their values until the next response or reset.
- Back-to-back operation: req_ready is high in the cycle where resp_valid is high, so a new request can be accepted at that edge. Its excitation uses q_in from that edge.
- A request presented while busy is not accepted; req_valid must be held until req_ready is high.
- When target == q_in at acceptance, the sequencer still runs DRIVE (j=k=0 in minimal/toggle modes) and CHECK, giving resp_ok = 1 after 2 cycles.
- Outside DRIVE, j_out = k_out = 0, so the bank holds.

Test Plan:
- Reset, then bank model at q=0000 -> j_out=k_out=0000, req_ready=1, resp_valid=0; the bank holds over 5 cycles.
- Minimal mode, q=0000, target 1010 -> in DRIVE j_out=1010, k_out=0000; q=1010 after E1; resp_valid pulse at E2+ with resp_ok=1, resp_retries=0.
- Toggle mode, q=1010, target 0110 -> j_out=k_out=1100; q=0110; resp_ok=1. Then force mode, target 0011 -> j_out=0011, k_out=1100; q=0011; resp_ok=1.
- Bank bit 0 stuck at 0, minimal mode, target 0001, MAX_RETRY=2 -> three DRIVE cycles, each with j_out=0001; resp_ok=0 and resp_retries=2 after 6 cycles.
- rst asserted during CHECK -> next cycle IDLE, j/k=0, busy=0, no resp_valid pulse. A request issued while busy is held off (req_ready=0) and accepted only after resp_valid.
- Back-to-back: second request accepted in the resp_valid cycle -> its DRIVE follows immediately and both responses are ok.
